// File: rtl/h12_to_h24_setter_pkg.sv
// Shared types and constants for the 12h/24h hour-setter block.
// The 24h-to-12h helper is used to seed the edit display.
package h12_to_h24_setter_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_EDIT = 1'b1
    } state_e;

    localparam logic [4:0] HOURS_PER_DAY = 5'd24;
    localparam logic [4:0] NOON          = 5'd12;
    localparam logic [4:0] LAST_HOUR     = HOURS_PER_DAY - 5'd1;
    localparam logic [3:0] NOON_H12      = 4'd12;

    localparam logic FLAG_AM = 1'b0;
    localparam logic FLAG_PM = 1'b1;

    typedef struct packed {
        logic [3:0] hour12;
        logic       nam_pm;
    } h12_t;

    function automatic h12_t h24_to_h12(input logic [4:0] h24);
        h12_t r;
        if (h24 == 5'd0) begin
            r.hour12 = NOON_H12;
            r.nam_pm = FLAG_AM;
        end else if (h24 < NOON) begin
            r.hour12 = h24[3:0];
            r.nam_pm = FLAG_AM;
        end else if (h24 == NOON) begin
            r.hour12 = NOON_H12;
            r.nam_pm = FLAG_PM;
        end else begin
            r.hour12 = 4'(h24 - NOON);
            r.nam_pm = FLAG_PM;
        end
        return r;
    endfunction

endpackage

// File: rtl/h12_to_h24_setter_conv.sv
// Combinational 12h (hour + AM/PM flag) to 24h converter with range flag.
module h12_to_h24_conv
    import h12_to_h24_setter_pkg::*;
(
    input  logic [3:0] hour12,
    input  logic       nAM_PM,
    output logic [4:0] hour24,
    output logic       in_range
);

    always_comb begin
        in_range = (hour12 != 4'd0) && (hour12 <= NOON_H12);
        hour24   = {1'b0, hour12};
        // 12 is the special case: midnight maps to 0, noon stays 12
        if (hour12 == NOON_H12) begin
            hour24 = (nAM_PM == FLAG_PM) ? NOON : 5'd0;
        end else if (nAM_PM == FLAG_PM) begin
            hour24 = {1'b0, hour12} + NOON;
        end
    end

endmodule

// File: rtl/h12_to_h24_setter.sv
// Running 24h hour register with a 12h-format edit session and a direct
// load handshake; edits and loads are converted to 24h when applied.
module h12_to_h24_setter
    import h12_to_h24_setter_pkg::*;
#(
    parameter int RESET_HOUR  = 0,
    parameter int TIMEOUT_CYC = 0,
    parameter int TIMEOUT_W   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_hour,
    input  logic       set_req,
    input  logic       btn_inc,
    input  logic       btn_ampm,
    input  logic       set_commit,
    input  logic       set_cancel,
    input  logic       load_valid,
    input  logic [3:0] load_hour12,
    input  logic       load_nAM_PM,
    output logic       load_ready,
    output logic       load_err,
    output logic [4:0] hour24,
    output logic       day_carry,
    output logic       editing,
    output logic [3:0] edit_hour12,
    output logic       edit_nAM_PM
);

    localparam logic [4:0]           RST_H24 = 5'(RESET_HOUR);
    localparam logic                 TO_EN   = (TIMEOUT_CYC > 0);
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

    state_e               state;
    state_e               state_nxt;
    logic [TIMEOUT_W-1:0] tmo_cnt;

    logic [4:0] ld_h24;
    logic       ld_in_range;
    logic [4:0] cm_h24;
    logic       cm_in_range;

    logic in_run;
    logic load_acc;
    logic load_ok;
    logic btn_any;
    logic tmo_hit;
    logic cancel_now;
    logic commit_now;
    h12_t seed;

    h12_to_h24_conv u_conv_load (
        .hour12   (load_hour12),
        .nAM_PM   (load_nAM_PM),
        .hour24   (ld_h24),
        .in_range (ld_in_range)
    );

    h12_to_h24_conv u_conv_commit (
        .hour12   (edit_hour12),
        .nAM_PM   (edit_nAM_PM),
        .hour24   (cm_h24),
        .in_range (cm_in_range)
    );

    assign in_run     = (state == ST_RUN);
    assign load_ready = in_run;
    assign editing    = (state == ST_EDIT);
    assign load_acc   = in_run && load_valid;
    assign load_ok    = load_acc && ld_in_range;
    assign btn_any    = btn_inc || btn_ampm;
    // A button press in the expiry cycle counts as activity and keeps the session
    assign tmo_hit    = TO_EN && !in_run && !btn_any && (tmo_cnt == TO_LAST);
    assign cancel_now = set_cancel || tmo_hit;
    assign commit_now = set_commit && cm_in_range && !cancel_now;
    // Seed from the hour as it stands before any same-cycle tick, or from an accepted load
    assign seed       = h24_to_h12(load_ok ? ld_h24 : hour24);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (set_req) begin
                    state_nxt = ST_EDIT;
                end
            end
            ST_EDIT: begin
                if (cancel_now || set_commit) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hour24      <= RST_H24;
            day_carry   <= 1'b0;
            load_err    <= 1'b0;
            edit_hour12 <= NOON_H12;
            edit_nAM_PM <= FLAG_AM;
            tmo_cnt     <= '0;
        end else begin
            day_carry <= 1'b0;
            load_err  <= 1'b0;
            if (in_run) begin
                tmo_cnt <= '0;
                // An accepted load, valid or not, swallows a same-cycle tick
                if (load_acc) begin
                    if (ld_in_range) begin
                        hour24 <= ld_h24;
                    end else begin
                        load_err <= 1'b1;
                    end
                end else if (tick_hour) begin
                    if (hour24 == LAST_HOUR) begin
                        hour24    <= 5'd0;
                        day_carry <= 1'b1;
                    end else begin
                        hour24 <= hour24 + 5'd1;
                    end
                end
                if (set_req) begin
                    edit_hour12 <= seed.hour12;
                    edit_nAM_PM <= seed.nam_pm;
                end
            end else begin
                if (commit_now) begin
                    hour24 <= cm_h24;
                end else if (tick_hour) begin
                    if (hour24 == LAST_HOUR) begin
                        hour24    <= 5'd0;
                        day_carry <= 1'b1;
                    end else begin
                        hour24 <= hour24 + 5'd1;
                    end
                end
                if (btn_inc) begin
                    edit_hour12 <= (edit_hour12 == NOON_H12) ? 4'd1 : edit_hour12 + 4'd1;
                end
                if (btn_ampm) begin
                    edit_nAM_PM <= ~edit_nAM_PM;
                end
                if (btn_any) begin
                    tmo_cnt <= '0;
                end else if (tmo_cnt != TO_LAST) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_h12_to_h24_setter.sv
// Bench for h12_to_h24_setter: directed scenarios plus randomized traffic
// checked every cycle against a behavioural hour/edit model.
module tb_h12_to_h24_setter;

    localparam int RESET_HOUR  = 0;
    localparam int TIMEOUT_CYC = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_hour = 1'b0;
    logic       set_req = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_ampm = 1'b0;
    logic       set_commit = 1'b0;
    logic       set_cancel = 1'b0;
    logic       load_valid = 1'b0;
    logic [3:0] load_hour12 = 4'd0;
    logic       load_nAM_PM = 1'b0;
    logic       load_ready;
    logic       load_err;
    logic [4:0] hour24;
    logic       day_carry;
    logic       editing;
    logic [3:0] edit_hour12;
    logic       edit_nAM_PM;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    h12_to_h24_setter #(
        .RESET_HOUR  (RESET_HOUR),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TIMEOUT_W   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_hour   (tick_hour),
        .set_req     (set_req),
        .btn_inc     (btn_inc),
        .btn_ampm    (btn_ampm),
        .set_commit  (set_commit),
        .set_cancel  (set_cancel),
        .load_valid  (load_valid),
        .load_hour12 (load_hour12),
        .load_nAM_PM (load_nAM_PM),
        .load_ready  (load_ready),
        .load_err    (load_err),
        .hour24      (hour24),
        .day_carry   (day_carry),
        .editing     (editing),
        .edit_hour12 (edit_hour12),
        .edit_nAM_PM (edit_nAM_PM)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: clock arithmetic on plain integers
    function automatic int to24(input int h, input bit pm);
        return (h % 12) + (pm ? 12 : 0);
    endfunction

    function automatic int h12_of(input int h);
        return ((h % 12) == 0) ? 12 : (h % 12);
    endfunction

    int m_hour, m_eh, m_idle;
    bit m_ep, m_edit, m_carry, m_err;
    int s_nh, s_seed;
    bit s_acc, s_ok, s_btn, s_cancel;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hour = RESET_HOUR; m_edit = 0; m_eh = 12; m_ep = 0;
            m_idle = 0; m_carry = 0; m_err = 0;
        end else begin
            s_nh = m_hour; m_carry = 0; m_err = 0;
            if (!m_edit) begin
                s_acc = load_valid;
                s_ok  = (load_hour12 >= 1) && (load_hour12 <= 12);
                if (s_acc) begin
                    if (s_ok) s_nh = to24(int'(load_hour12), load_nAM_PM);
                    else m_err = 1;
                end else if (tick_hour) begin
                    m_carry = (m_hour == 23);
                    s_nh = (m_hour + 1) % 24;
                end
                if (set_req) begin
                    s_seed = (s_acc && s_ok) ? s_nh : m_hour;
                    m_eh = h12_of(s_seed);
                    m_ep = (s_seed >= 12);
                    m_edit = 1;
                    m_idle = 0;
                end
            end else begin
                s_btn = btn_inc || btn_ampm;
                s_cancel = set_cancel || (!s_btn && m_idle == TIMEOUT_CYC - 1);
                if (set_commit && !s_cancel) begin
                    s_nh = to24(m_eh, m_ep);
                end else if (tick_hour) begin
                    m_carry = (m_hour == 23);
                    s_nh = (m_hour + 1) % 24;
                end
                if (btn_inc) m_eh = (m_eh % 12) + 1;
                if (btn_ampm) m_ep = !m_ep;
                m_idle = s_btn ? 0 : m_idle + 1;
                if (s_cancel || set_commit) m_edit = 0;
            end
            m_hour = s_nh;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_hour24", int'(hour24), m_hour);
            chk("m_day_carry", int'(day_carry), int'(m_carry));
            chk("m_load_err", int'(load_err), int'(m_err));
            chk("m_editing", int'(editing), int'(m_edit));
            chk("m_load_ready", int'(load_ready), int'(!m_edit));
            chk("m_edit_hour12", int'(edit_hour12), m_eh);
            chk("m_edit_nAM_PM", int'(edit_nAM_PM), int'(m_ep));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_load(input int h, input bit pm);
        load_valid = 1'b1;
        load_hour12 = 4'(h);
        load_nAM_PM = pm;
        step();
        load_valid = 1'b0;
    endtask

    task automatic pulse_req();
        set_req = 1'b1; step(); set_req = 1'b0;
    endtask

    task automatic pulse_inc();
        btn_inc = 1'b1; step(); btn_inc = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int carries;
        int n;
        int btn_div;
        #12 rst = 1'b0;
        #1;
        chk("rst_hour24", int'(hour24), RESET_HOUR);
        chk("rst_editing", int'(editing), 0);
        chk("rst_edit_hour12", int'(edit_hour12), 12);
        chk("rst_edit_nAM_PM", int'(edit_nAM_PM), 0);
        chk("rst_load_ready", int'(load_ready), 1);
        chk("rst_day_carry", int'(day_carry), 0);
        chk("rst_load_err", int'(load_err), 0);
        step();

        carries = 0;
        for (int i = 0; i < 24; i++) begin
            tick_hour = 1'b1; step(); tick_hour = 1'b0;
            carries += int'(day_carry);
            chk("tick_hour24", int'(hour24), (i + 1) % 24);
            if (i == 23) chk("tick_wrap_carry", int'(day_carry), 1);
        end
        chk("tick_carry_count", carries, 1);

        do_load(12, 1'b1); chk("load_12pm", int'(hour24), 12);
        do_load(12, 1'b0); chk("load_12am", int'(hour24), 0);
        do_load(7, 1'b1);  chk("load_7pm", int'(hour24), 19);
        do_load(11, 1'b0); chk("load_11am", int'(hour24), 11);
        do_load(0, 1'b0);  chk("load0_err", int'(load_err), 1);
        chk("load0_hour", int'(hour24), 11);
        step();            chk("load0_err_clear", int'(load_err), 0);
        do_load(13, 1'b1); chk("load13_err", int'(load_err), 1);
        chk("load13_hour", int'(hour24), 11);
        step();            chk("load13_err_clear", int'(load_err), 0);

        do_load(3, 1'b1);  chk("load_3pm", int'(hour24), 15);
        pulse_req();
        chk("edit_enter", int'(editing), 1);
        chk("edit_seed_h", int'(edit_hour12), 3);
        chk("edit_seed_pm", int'(edit_nAM_PM), 1);
        repeat (10) pulse_inc();
        chk("edit_inc_wrap", int'(edit_hour12), 1);
        btn_ampm = 1'b1; step(); btn_ampm = 1'b0;
        chk("edit_ampm", int'(edit_nAM_PM), 0);
        set_commit = 1'b1; step(); set_commit = 1'b0;
        chk("commit_hour", int'(hour24), 1);
        chk("commit_run", int'(editing), 0);

        do_load(9, 1'b0);
        pulse_req(); pulse_inc(); pulse_inc();
        set_commit = 1'b1; tick_hour = 1'b1; step(); set_commit = 1'b0; tick_hour = 1'b0;
        chk("commit_tick_hour", int'(hour24), 11);
        chk("commit_tick_carry", int'(day_carry), 0);

        do_load(9, 1'b0);
        pulse_req(); pulse_inc();
        set_commit = 1'b1; set_cancel = 1'b1; step(); set_commit = 1'b0; set_cancel = 1'b0;
        chk("commit_cancel_hour", int'(hour24), 9);
        chk("commit_cancel_run", int'(editing), 0);

        pulse_req();
        load_valid = 1'b1; load_hour12 = 4'd5; load_nAM_PM = 1'b0;
        chk("edit_load_ready", int'(load_ready), 0);
        step(); step();
        pulse_inc();
        n = 0;
        while (n < 20) begin
            step();
            n++;
            if (!editing) break;
        end
        load_valid = 1'b0;
        chk("timeout_cycles", n, 8);
        chk("timeout_hour", int'(hour24), 9);
        step();
        chk("timeout_noload", int'(hour24), 9);

        pulse_req(); pulse_inc();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_hour24", int'(hour24), RESET_HOUR);
        chk("arst_editing", int'(editing), 0);
        chk("arst_edit_hour12", int'(edit_hour12), 12);
        #3 rst = 1'b0;
        step();

        for (int i = 0; i < 5000; i++) begin
            btn_div = (i < 2500) ? 3 : 20;
            tick_hour   = ($urandom_range(0, 3) == 0);
            set_req     = ($urandom_range(0, 15) == 0);
            btn_inc     = ($urandom_range(0, btn_div - 1) == 0);
            btn_ampm    = ($urandom_range(0, 2 * btn_div - 1) == 0);
            set_commit  = ($urandom_range(0, 11) == 0);
            set_cancel  = ($urandom_range(0, 19) == 0);
            load_valid  = ($urandom_range(0, 7) == 0);
            load_hour12 = 4'($urandom_range(0, 15));
            load_nAM_PM = 1'($urandom_range(0, 1));
            step();
        end
        tick_hour = 0; set_req = 0; btn_inc = 0; btn_ampm = 0;
        set_commit = 0; set_cancel = 0; load_valid = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
